// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with stall hold, programmable reset
// vector, target alignment check and an optional return-address stack.
// Optional feature macro: PC_RAS_EN (defined -> RAS built; undefined -> call
// acts as jump, ret acts as a sequential step flagged as underflow).
module pc_unit #(
   parameter int                ADDR_W    = 16,
   parameter int                INC       = 4,
   parameter logic [ADDR_W-1:0] RESET_VEC = '0,
   parameter int                RAS_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              br,
   input  logic              jump,
   input  logic              call,
   input  logic              ret,
   input  logic [ADDR_W-1:0] br_add,
   input  logic [ADDR_W-1:0] jump_add,
   output logic [ADDR_W-1:0] pc,
   output logic              misalign,
   output logic              sel_conf,
   output logic              ras_empty,
   output logic              ras_full,
   output logic              ras_ovf,
   output logic              ras_unf
);

   localparam logic [ADDR_W-1:0] INC_V      = ADDR_W'(INC);
   // INC is a power of two, so INC-1 masks exactly the low log2(INC) bits
   // (and is zero for INC=1, which makes misalign constant 0).
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INC - 1);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] pc_seq;
   logic [ADDR_W-1:0] tgt;
   logic              load;
   logic              misalign_q, misalign_d;
   logic              sel_conf_q, sel_conf_d;
   logic              ras_ovf_q, ras_ovf_d;
   logic              ras_unf_q, ras_unf_d;
   logic [2:0]        req_cnt;
   logic              ras_avail;
   logic              ras_is_full;
   logic [ADDR_W-1:0] ras_top;

   // Sequential successor wraps naturally at 2^ADDR_W.
   assign pc_seq  = pc_q + INC_V;
   assign req_cnt = {2'b00, br} + {2'b00, jump} + {2'b00, call} + {2'b00, ret};

`ifdef PC_RAS_EN
   localparam int SP_W = $clog2(RAS_DEPTH);

   logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
   logic [SP_W-1:0]   sp_q, sp_d;
   logic [SP_W:0]     cnt_q, cnt_d;
   logic              push, pop;

   assign ras_avail   = (cnt_q != '0);
   assign ras_is_full = (cnt_q == (SP_W + 1)'(RAS_DEPTH));
   // sp points at the next free slot, so the top lives one below it.
   assign ras_top     = ras_mem[sp_q - SP_W'(1)];
   assign push        = !stall && !ret && call;
   assign pop         = !stall && ret && ras_avail;

   // Stack pointer and occupancy; a push into a full stack overwrites the
   // oldest entry (sp wraps onto it) while the count saturates.
   always_comb begin
      sp_d  = sp_q;
      cnt_d = cnt_q;
      if (push) begin
         sp_d = sp_q + SP_W'(1);
         if (!ras_is_full) cnt_d = cnt_q + (SP_W + 1)'(1);
      end else if (pop) begin
         sp_d  = sp_q - SP_W'(1);
         cnt_d = cnt_q - (SP_W + 1)'(1);
      end
   end

   // Stack control state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         sp_q  <= '0;
         cnt_q <= '0;
      end else begin
         sp_q  <= sp_d;
         cnt_q <= cnt_d;
      end
   end

   // Return-address storage; contents are meaningless while count is zero.
   always_ff @(posedge clk) begin
      if (push) ras_mem[sp_q] <= pc_seq;
   end
`else
   assign ras_avail   = 1'b0;
   // RAS_DEPTH is at least 2, so this is constant 0.
   assign ras_is_full = (RAS_DEPTH == 0);
   assign ras_top     = '0;
`endif

   // Next-PC selection: ret > call > jump > br > sequential; stall freezes all.
   always_comb begin
      pc_d       = pc_q;
      tgt        = pc_seq;
      load       = 1'b0;
      sel_conf_d = 1'b0;
      ras_ovf_d  = 1'b0;
      ras_unf_d  = 1'b0;
      if (!stall) begin
         sel_conf_d = (req_cnt > 3'd1);
         if (ret) begin
            if (ras_avail) begin
               tgt  = ras_top;
               load = 1'b1;
            end else begin
               ras_unf_d = 1'b1;
            end
         end else if (call) begin
            tgt       = jump_add;
            load      = 1'b1;
            ras_ovf_d = ras_is_full;
         end else if (jump) begin
            tgt  = jump_add;
            load = 1'b1;
         end else if (br) begin
            tgt  = br_add;
            load = 1'b1;
         end
         pc_d = tgt;
      end
      misalign_d = load && ((tgt & ALIGN_MASK) != '0);
   end

   // PC and one-cycle status pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q       <= RESET_VEC;
         misalign_q <= 1'b0;
         sel_conf_q <= 1'b0;
         ras_ovf_q  <= 1'b0;
         ras_unf_q  <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         misalign_q <= misalign_d;
         sel_conf_q <= sel_conf_d;
         ras_ovf_q  <= ras_ovf_d;
         ras_unf_q  <= ras_unf_d;
      end
   end

   assign pc        = pc_q;
   assign misalign  = misalign_q;
   assign sel_conf  = sel_conf_q;
   assign ras_ovf   = ras_ovf_q;
   assign ras_unf   = ras_unf_q;
   assign ras_empty = !ras_avail;
   assign ras_full  = ras_is_full;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed scenarios plus randomized traffic for pc_unit, checked
// against a queue-based reference model of the PC/RAS behaviour.
module tb_pc_unit;

   localparam int          ADDR_W    = 16;
   localparam int          INC       = 4;
   localparam logic [15:0] RESET_VEC = 16'h0100;
   localparam int          RAS_DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst, stall, br, jump, call, ret;
   logic [15:0] br_add, jump_add;
   logic [15:0] pc;
   logic        misalign, sel_conf, ras_empty, ras_full, ras_ovf, ras_unf;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model state
   logic [15:0] e_pc;
   logic        e_mis, e_sel, e_ovf, e_unf;
   logic [15:0] m_ras[$];

   pc_unit #(
      .ADDR_W(ADDR_W), .INC(INC), .RESET_VEC(RESET_VEC), .RAS_DEPTH(RAS_DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .stall(stall), .br(br), .jump(jump), .call(call), .ret(ret),
      .br_add(br_add), .jump_add(jump_add), .pc(pc), .misalign(misalign),
      .sel_conf(sel_conf), .ras_empty(ras_empty), .ras_full(ras_full),
      .ras_ovf(ras_ovf), .ras_unf(ras_unf)
   );

   always #5 clk = ~clk;

   function automatic logic e_empty();
`ifdef PC_RAS_EN
      return m_ras.size() == 0;
`else
      return 1'b1;
`endif
   endfunction

   function automatic logic e_full();
`ifdef PC_RAS_EN
      return m_ras.size() == RAS_DEPTH;
`else
      return 1'b0;
`endif
   endfunction

   // Drive one cycle of inputs, advance the model, then step past the edge.
   task automatic cyc(input logic r, input logic s, input logic b, input logic j,
                      input logic c, input logic rt, input logic [15:0] ba,
                      input logic [15:0] ja);
      logic [15:0] seq, t;
      logic        ld;
      rst = r; stall = s; br = b; jump = j; call = c; ret = rt;
      br_add = ba; jump_add = ja;
      seq = e_pc + 16'(INC);
      ld = 1'b0; t = seq;
      e_mis = 1'b0; e_sel = 1'b0; e_ovf = 1'b0; e_unf = 1'b0;
      if (r) begin
         e_pc = RESET_VEC;
         m_ras.delete();
      end else if (!s) begin
         e_sel = (int'(b) + int'(j) + int'(c) + int'(rt)) > 1;
         if (rt) begin
`ifdef PC_RAS_EN
            if (m_ras.size() > 0) begin
               t = m_ras.pop_back();
               ld = 1'b1;
            end else e_unf = 1'b1;
`else
            e_unf = 1'b1;
`endif
         end else if (c) begin
            t = ja; ld = 1'b1;
`ifdef PC_RAS_EN
            m_ras.push_back(seq);
            if (m_ras.size() > RAS_DEPTH) begin
               void'(m_ras.pop_front());
               e_ovf = 1'b1;
            end
`endif
         end else if (j) begin
            t = ja; ld = 1'b1;
         end else if (b) begin
            t = ba; ld = 1'b1;
         end
         e_pc  = t;
         e_mis = ld && (t % INC != 0);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
   endtask

   task automatic do_rst();
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
   endtask

   task automatic test_reset();
      logic [15:0] want;
      do_rst();
      n_chk++;
      if (pc !== 16'h0100) $display("FAIL reset_pc: got %h want 0100", pc);
      else n_pass++;
      n_chk++;
      if ({misalign, sel_conf, ras_ovf, ras_unf, ras_empty, ras_full} !== 6'b000010)
         $display("FAIL reset_flags: got %b want 000010",
                  {misalign, sel_conf, ras_ovf, ras_unf, ras_empty, ras_full});
      else n_pass++;
      for (int i = 1; i <= 3; i++) begin
         idle();
         want = 16'h0100 + 16'(4 * i);
         n_chk++;
         if (pc !== want) $display("FAIL seq_%0d: got %h want %h", i, pc, want);
         else n_pass++;
      end
      do_rst();
      n_chk++;
      if (pc !== 16'h0100) $display("FAIL midrun_reset: got %h want 0100", pc);
      else n_pass++;
   endtask

   task automatic test_stall_branch();
      do_rst();
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0200, 16'h0);
      n_chk++;
      if (pc !== 16'h0100) $display("FAIL stall_hold: got %h want 0100", pc);
      else n_pass++;
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0200, 16'h0);
      n_chk++;
      if (pc !== 16'h0200) $display("FAIL branch: got %h want 0200", pc);
      else n_pass++;
      idle();
      n_chk++;
      if (pc !== 16'h0204) $display("FAIL after_branch: got %h want 0204", pc);
      else n_pass++;
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFC, 16'h0);
      idle();
      n_chk++;
      if ({pc, misalign} !== {16'h0000, 1'b0})
         $display("FAIL wrap: got pc %h mis %b want 0000 0", pc, misalign);
      else n_pass++;
   endtask

   task automatic test_conflict_misalign();
      do_rst();
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0200, 16'h0300);
      n_chk++;
      if ({pc, sel_conf, misalign} !== {16'h0300, 1'b1, 1'b0})
         $display("FAIL conflict: got pc %h sel %b mis %b want 0300 1 0", pc, sel_conf, misalign);
      else n_pass++;
      idle();
      n_chk++;
      if ({pc, sel_conf} !== {16'h0304, 1'b0})
         $display("FAIL conflict_pulse: got pc %h sel %b want 0304 0", pc, sel_conf);
      else n_pass++;
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0302);
      n_chk++;
      if ({pc, misalign} !== {16'h0302, 1'b1})
         $display("FAIL misalign: got pc %h mis %b want 0302 1", pc, misalign);
      else n_pass++;
      idle();
      n_chk++;
      if ({pc, misalign} !== {16'h0306, 1'b0})
         $display("FAIL misalign_pulse: got pc %h mis %b want 0306 0", pc, misalign);
      else n_pass++;
   endtask

`ifdef PC_RAS_EN
   task automatic test_ras_basic();
      logic [15:0] want [4] = '{16'h0400, 16'h0500, 16'h0404, 16'h0104};
      do_rst();
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0400);
      n_chk++;
      if ({pc, ras_empty} !== {want[0], 1'b0}) $display("FAIL call1: got %h %b", pc, ras_empty);
      else n_pass++;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0500);
      n_chk++;
      if (pc !== want[1]) $display("FAIL call2: got %h want %h", pc, want[1]);
      else n_pass++;
      for (int i = 2; i < 4; i++) begin
         cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
         n_chk++;
         if (pc !== want[i]) $display("FAIL ret_%0d: got %h want %h", i - 1, pc, want[i]);
         else n_pass++;
      end
      n_chk++;
      if (ras_empty !== 1'b1) $display("FAIL ras_empty_after: got %b want 1", ras_empty);
      else n_pass++;
   endtask

   task automatic test_ras_overflow();
      logic [15:0] want;
      do_rst();
      for (int k = 1; k <= 5; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'(k * 16'h1000));
      n_chk++;
      if ({ras_ovf, ras_full, pc} !== {1'b1, 1'b1, 16'h5000})
         $display("FAIL ovf: got ovf %b full %b pc %h want 1 1 5000", ras_ovf, ras_full, pc);
      else n_pass++;
      for (int k = 4; k >= 1; k--) begin
         cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
         want = 16'(k * 16'h1000) + 16'h0004;
         n_chk++;
         if ({pc, ras_unf} !== {want, 1'b0}) $display("FAIL ovf_ret: got %h %b want %h 0", pc, ras_unf, want);
         else n_pass++;
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
      n_chk++;
      if ({pc, ras_unf, ras_empty} !== {16'h1008, 1'b1, 1'b1})
         $display("FAIL unf: got pc %h unf %b empty %b want 1008 1 1", pc, ras_unf, ras_empty);
      else n_pass++;
   endtask
`else
   task automatic test_no_ras();
      do_rst();
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0400);
      n_chk++;
      if ({pc, ras_empty, ras_ovf} !== {16'h0400, 1'b1, 1'b0})
         $display("FAIL noras_call: got pc %h empty %b ovf %b want 0400 1 0", pc, ras_empty, ras_ovf);
      else n_pass++;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
      n_chk++;
      if ({pc, ras_unf, ras_full} !== {16'h0404, 1'b1, 1'b0})
         $display("FAIL noras_ret: got pc %h unf %b full %b want 0404 1 0", pc, ras_unf, ras_full);
      else n_pass++;
   endtask
`endif

   task automatic test_random();
      logic [15:0] ba, ja;
      logic [6:0]  got, want;
      for (int n = 0; n < 400; n++) begin
         ba = 16'($urandom);
         ja = 16'($urandom);
         if ($urandom_range(0, 3) != 0) ba[1:0] = 2'b00;
         if ($urandom_range(0, 3) != 0) ja[1:0] = 2'b00;
         cyc($urandom_range(0, 39) == 0, $urandom_range(0, 4) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, ba, ja);
         n_chk++;
         if (pc !== e_pc) $display("FAIL rand_pc[%0d]: got %h want %h", n, pc, e_pc);
         else n_pass++;
         got  = {misalign, sel_conf, ras_ovf, ras_unf, ras_empty, ras_full, 1'b0};
         want = {e_mis, e_sel, e_ovf, e_unf, e_empty(), e_full(), 1'b0};
         n_chk++;
         if (got !== want) $display("FAIL rand_flags[%0d]: got %b want %b", n, got, want);
         else n_pass++;
      end
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; br = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0;
      br_add = '0; jump_add = '0;
      e_pc = RESET_VEC; e_mis = 1'b0; e_sel = 1'b0; e_ovf = 1'b0; e_unf = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_stall_branch();
      test_conflict_misalign();
`ifdef PC_RAS_EN
      test_ras_basic();
      test_ras_overflow();
`else
      test_no_ras();
`endif
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
